// File: rtl/bram_log_pkg.sv
// Shared definitions for the TX debug capture buffer: state encoding and
// the address-width helper used to size pointers and read addresses.
package bram_log_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOG  = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_LOG  = LOG,
        ST_FULL = FULL
    } state_t;

    // Number of bits needed to represent value; clogb2(1023) == 10.
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bram_log_if.sv
// Capture-control and readout signals between the log reader and bram_log.
// The master side (reader/TX) drives the inputs; bram_log is the slave.
interface bram_log_if
    import bram_log_pkg::*;
#(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
);

    localparam int AW = clogb2(RAM_DEPTH - 1);

    logic                 i_run_log;
    logic                 i_read_log;
    logic [RAM_WIDTH-1:0] i_data_tx_to_mem;
    logic [AW-1:0]        i_addr_log_to_mem;
    logic [RAM_WIDTH-1:0] o_data_log_from_mem;
    logic                 o_mem_full;

    modport master (
        output i_run_log,
        output i_read_log,
        output i_data_tx_to_mem,
        output i_addr_log_to_mem,
        input  o_data_log_from_mem,
        input  o_mem_full
    );

    modport slave (
        input  i_run_log,
        input  i_read_log,
        input  i_data_tx_to_mem,
        input  i_addr_log_to_mem,
        output o_data_log_from_mem,
        output o_mem_full
    );

endinterface

// File: rtl/bram_log_sdp.sv
// Simple dual-port block RAM: one write port, one registered read-first read
// port. The array has no reset so it maps onto vendor BRAM.
module bram_sdp #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives read-first on an address collision;
    // addresses beyond the array (non power-of-two depth) read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ({1'b0, raddr} < DEPTH_W) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/bram_log.sv
// Capture buffer for the TX debug logger: a run pulse records one TX sample
// per clock until the RAM is full; samples are read back by address.
module bram_log
    import bram_log_pkg::*;
#(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
) (
    input  logic     clk,
    input  logic     reset,
    bram_log_if.slave bus
);

    localparam int            AW        = clogb2(RAM_DEPTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    state_t               state;
    state_t               next_state;
    logic [AW-1:0]        wr_ptr;
    logic                 mem_full;
    logic                 wr_en;
    logic [RAM_WIDTH-1:0] rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Run is only honoured outside LOG, so a capture always completes.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_run_log) next_state = ST_LOG;
            end
            ST_LOG: begin
                wr_en = 1'b1;
                if (wr_ptr == LAST_ADDR) next_state = ST_FULL;
            end
            ST_FULL: begin
                if (bus.i_run_log) next_state = ST_LOG;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            mem_full <= 1'b0;
        end else begin
            if (state == ST_LOG) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (bus.i_run_log) begin
                wr_ptr <= '0;
            end

            if (state == ST_LOG && wr_ptr == LAST_ADDR) begin
                mem_full <= 1'b1;
            end else if (state != ST_LOG && bus.i_run_log) begin
                mem_full <= 1'b0;
            end
        end
    end

    bram_sdp #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.i_data_tx_to_mem),
        .re    (bus.i_read_log),
        .raddr (bus.i_addr_log_to_mem),
        .rdata (rd_data)
    );

    assign bus.o_data_log_from_mem = rd_data;
    assign bus.o_mem_full          = mem_full;

endmodule

// File: tb/tb_bram_log.sv
// Directed bench for bram_log: capture timing, readback table, hold, FULL
// write-protection, read-first collision and asynchronous reset abort.
module tb_bram_log;

    localparam int RAM_WIDTH = 18;
    localparam int RAM_DEPTH = 1024;
    localparam int AW        = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bram_log_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

    bram_log #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic                 re;
        logic [RAM_WIDTH-1:0] expected;
    } read_vec_t;

    read_vec_t vecs [8];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one read request before the next edge, then sample at the negedge.
    task automatic apply_stimulus(input logic [AW-1:0] addr, input logic re);
        bus.i_addr_log_to_mem = addr;
        bus.i_read_log        = re;
        @(negedge clk);
    endtask

    logic early_full;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{addr: 10'd31,   re: 1'b1, expected: 18'd31};
        vecs[1] = '{addr: 10'd32,   re: 1'b1, expected: 18'd32};
        vecs[2] = '{addr: 10'd33,   re: 1'b1, expected: 18'd33};
        vecs[3] = '{addr: 10'd500,  re: 1'b0, expected: 18'd33};
        vecs[4] = '{addr: 10'd700,  re: 1'b0, expected: 18'd33};
        vecs[5] = '{addr: 10'd0,    re: 1'b1, expected: 18'd0};
        vecs[6] = '{addr: 10'd1023, re: 1'b1, expected: 18'd1023};
        vecs[7] = '{addr: 10'd500,  re: 1'b1, expected: 18'd500};

        reset                 = 1'b0;
        bus.i_run_log         = 1'b0;
        bus.i_read_log        = 1'b0;
        bus.i_data_tx_to_mem  = '0;
        bus.i_addr_log_to_mem = '0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("rst_full", 32'(bus.o_mem_full), 32'd0);
            check_output("rst_data", 32'(bus.o_data_log_from_mem), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_full", 32'(bus.o_mem_full), 32'd0);
        check_output("post_rst_data", 32'(bus.o_data_log_from_mem), 32'd0);

        // First capture: sample k goes to address k; a run pulse at sample 100 is ignored.
        bus.i_run_log = 1'b1;
        @(negedge clk);
        early_full = 1'b0;
        for (int k = 0; k < RAM_DEPTH; k++) begin
            bus.i_data_tx_to_mem = RAM_WIDTH'(k);
            bus.i_run_log        = (k == 100);
            if (bus.o_mem_full !== 1'b0) early_full = 1'b1;
            @(negedge clk);
        end
        bus.i_run_log = 1'b0;
        check_output("early_full", 32'(early_full), 32'd0);
        check_output("full_after_1024", 32'(bus.o_mem_full), 32'd1);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].re);
            check_output($sformatf("read_vec%0d", i), 32'(bus.o_data_log_from_mem),
                         32'(vecs[i].expected));
        end

        // No writes while FULL, even with data toggling.
        bus.i_read_log = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.i_data_tx_to_mem = 18'h3ffff;
            @(negedge clk);
        end
        check_output("full_hold", 32'(bus.o_mem_full), 32'd1);
        apply_stimulus(10'd31, 1'b1);
        check_output("full_no_write_31", 32'(bus.o_data_log_from_mem), 32'd31);
        apply_stimulus(10'd1023, 1'b1);
        check_output("full_no_write_1023", 32'(bus.o_data_log_from_mem), 32'd1023);

        // Restart from FULL, then collide a read with the write of address 5.
        bus.i_read_log = 1'b0;
        bus.i_run_log  = 1'b1;
        @(negedge clk);
        bus.i_run_log = 1'b0;
        check_output("restart_clears_full", 32'(bus.o_mem_full), 32'd0);
        for (int k = 0; k < 20; k++) begin
            bus.i_data_tx_to_mem  = 18'h20000 + RAM_WIDTH'(k);
            bus.i_addr_log_to_mem = 10'd5;
            bus.i_read_log        = (k == 5 || k == 6);
            @(negedge clk);
            if (k == 5) check_output("read_first", 32'(bus.o_data_log_from_mem), 32'd5);
            if (k == 6) check_output("read_new", 32'(bus.o_data_log_from_mem), 32'h20005);
        end
        bus.i_read_log = 1'b0;

        // Asynchronous reset between edges aborts the second capture.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_rst_data", 32'(bus.o_data_log_from_mem), 32'd0);
        check_output("async_rst_full", 32'(bus.o_mem_full), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 1100; k++) begin
            bus.i_data_tx_to_mem = 18'h1ffff;
            @(negedge clk);
        end
        check_output("idle_after_rst", 32'(bus.o_mem_full), 32'd0);
        apply_stimulus(10'd19, 1'b1);
        check_output("kept_second_run", 32'(bus.o_data_log_from_mem), 32'h20013);
        apply_stimulus(10'd50, 1'b1);
        check_output("kept_first_run", 32'(bus.o_data_log_from_mem), 32'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_log.md
# bram_log

Capture buffer for the transmit-side debug logger. On a one-cycle start pulse it records one sample of the TX data stream per clock into an on-chip block RAM until the RAM is full. It then flags full, and software or the log reader fetches samples by address. It sits between the TX datapath and the log-readout interface.

## Interface
Parameters:
- RAM_WIDTH, 18, sample width in bits
- RAM_DEPTH, 1024, number of samples; address width AW = clogb2(RAM_DEPTH-1), which is 10 for 1024

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_run_log  in  1  start-capture pulse
- i_read_log  in  1  read enable
- i_data_tx_to_mem  in  RAM_WIDTH  TX sample to record
- i_addr_log_to_mem  in  AW  read address
- o_data_log_from_mem  out  RAM_WIDTH  read data, registered
- o_mem_full  out  1  capture complete, memory holds RAM_DEPTH samples

## Operation
- State machine has three states: IDLE, LOG, FULL. Write pointer wr_ptr is AW bits wide.
- IDLE: on an edge with i_run_log=1, go to LOG, set wr_ptr=0, clear o_mem_full.
- LOG: each edge writes i_data_tx_to_mem to mem[wr_ptr] and increments wr_ptr.
  - The edge that writes address RAM_DEPTH-1 moves to FULL and sets o_mem_full=1.
  - i_run_log is ignored in LOG.
- FULL: no writes. o_mem_full stays 1.
  - i_run_log=1 restarts capture: go to LOG, wr_ptr=0, o_mem_full=0, old contents are overwritten progressively.
- Read: on an edge with i_read_log=1, o_data_log_from_mem <= mem[i_addr_log_to_mem].
  - Reads are honoured in every state.
  - i_read_log=0 holds the last output value.
- Read and write to the same address on the same edge returns the old contents (read-first).
- Addresses >= RAM_DEPTH (possible when RAM_DEPTH is not a power of two) return 0.
- Reset (reset=0, asynchronous):
  - state=IDLE, wr_ptr=0, o_mem_full=0, o_data_log_from_mem=0.
  - RAM contents are not cleared.
  - Reset during LOG aborts the capture; only samples written before reset remain valid.

## Timing
- Start: if i_run_log is high at edge N, the first sample (address 0) is the value present at edge N+1.
- The sample present at edge N+1+k lands in address k.
- o_mem_full rises right after edge N+RAM_DEPTH and stays high until restart or reset.
- Read latency is 1 clock: address and i_read_log sampled at edge M, data valid after edge M and held until the next enabled read.
- No back-pressure and no handshake. The capture rate is fixed at one sample per clock.

## Structure
- Shared package bram_log_pkg holds:
  - the clogb2 function
  - state encoding localparams IDLE=2'd0, LOG=2'd1, FULL=2'd2
- One sub-module is natural: bram_sdp, a simple dual-port block RAM.
  - Ports: one write port (we, waddr, wdata) and one registered read port (re, raddr, rdata), read-first.
  - Inferable as vendor BRAM with no reset on the array.
- The top level holds the FSM, the write pointer and the full flag.

## Test plan
- Reset with reset=0 for 5 cycles -> o_mem_full=0, o_data_log_from_mem=0 during and after reset.
- Pulse i_run_log for 1 cycle, then drive data = 0,1,2,… one value per clock for 1024 clocks -> o_mem_full=1 exactly after the 1024th sample. No earlier assertion.
- After full, read addresses 31, 32, 33 with i_read_log=1 -> outputs 31, 32, 33, each valid one clock after its address. Address 0 returns 0 and address 1023 returns 1023.
- Drop i_read_log and change the address to 500 -> output holds 33.
- After full, drive more data without i_run_log -> contents unchanged (address 31 still reads 31).
- Pulse i_run_log during LOG at sample 100 -> ignored, and full still asserts after 1024 samples. Then assert reset=0 mid-capture of a second run -> o_mem_full=0 immediately (asynchronous) and the FSM returns to IDLE.
